// File: rtl/ldp_transport_ctrl.sv
// Laserdisc transport sequencer: play/pause/search control, decoder CTRL register writes,
// frame-search handshake with the stream feeder and vsync-driven frame tracking.
//
// state          | meaning
// ST_STOP        | idle after reset, decoder not started
// ST_PLAY        | decoder running, cur_frame advances on vsync
// ST_PAUSE       | decoder frozen on cur_frame
// ST_SRCH_FLUSH  | one cycle: flush decoder, raise frame_search_req
// ST_SRCH_WAIT   | waiting for search_ack, timeout timer running
// ST_SRCH_SETTLE | waiting for decoder to go idle before resuming
module ldp_transport_ctrl #(
   parameter int unsigned FRAME_W       = 32,
   parameter int unsigned MAX_FRAME     = 54000,
   parameter int unsigned TIMEOUT_CYC   = 50000000,
   parameter logic [4:0]  REG_CTRL_ADDR = 5'd0
) (
   input  logic               sys_clk,
   input  logic               rst,
   input  logic               play_req,
   input  logic               pause_req,
   input  logic               search_req,
   input  logic [FRAME_W-1:0] search_frame_in,
   input  logic               search_ack,
   input  logic               mpeg_busy,
   input  logic               v_sync,
   output logic               frame_search_req,
   output logic [FRAME_W-1:0] frame_search,
   output logic [4:0]         reg_addr,
   output logic               reg_wr_en,
   output logic [31:0]        reg_dta_in,
   output logic               is_playing,
   output logic               is_paused,
   output logic               is_searching,
   output logic [FRAME_W-1:0] cur_frame,
   output logic               search_err
);

   localparam int unsigned        TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [FRAME_W-1:0] MAX_F = FRAME_W'(MAX_FRAME);
   localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      ST_STOP,
      ST_PLAY,
      ST_PAUSE,
      ST_SRCH_FLUSH,
      ST_SRCH_WAIT,
      ST_SRCH_SETTLE
   } state_t;

   state_t             state, next_state;
   logic               pending_play, pend_nxt, pend_eff;
   logic               v_sync_q, vs_rise;
   logic [TMR_W-1:0]   tmr;
   logic               srch_start, srch_done, srch_tmo, inc_frame;
   logic               wr_go;
   logic [31:0]        wr_dta;
   logic [FRAME_W-1:0] clamp_frame;

   assign vs_rise     = v_sync & ~v_sync_q;
   assign clamp_frame = (search_frame_in > MAX_F) ? MAX_F : search_frame_in;
   // requests seen during a search only steer where the search ends up
   assign pend_eff    = pause_req ? 1'b0 : (play_req ? 1'b1 : pending_play);

   always_comb begin
      next_state = state;
      pend_nxt   = pending_play;
      srch_start = 1'b0;
      srch_done  = 1'b0;
      srch_tmo   = 1'b0;
      inc_frame  = 1'b0;
      case (state)
         ST_STOP: begin
            if (search_req) begin
               next_state = ST_SRCH_FLUSH;
               srch_start = 1'b1;
            end else if (!pause_req && play_req) begin
               next_state = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (search_req) begin
               next_state = ST_SRCH_FLUSH;
               srch_start = 1'b1;
            end else if (pause_req) begin
               next_state = ST_PAUSE;
            end else if (vs_rise) begin
               if (cur_frame == MAX_F) next_state = ST_PAUSE;
               else                    inc_frame  = 1'b1;
            end
         end
         ST_PAUSE: begin
            if (search_req) begin
               next_state = ST_SRCH_FLUSH;
               srch_start = 1'b1;
            end else if (!pause_req && play_req) begin
               next_state = ST_PLAY;
            end
         end
         ST_SRCH_FLUSH: begin
            pend_nxt   = pend_eff;
            next_state = ST_SRCH_WAIT;
         end
         ST_SRCH_WAIT: begin
            pend_nxt = pend_eff;
            if (search_ack) begin
               next_state = ST_SRCH_SETTLE;
               srch_done  = 1'b1;
            end else if (tmr == '0) begin
               next_state = ST_PAUSE;
               srch_tmo   = 1'b1;
               pend_nxt   = 1'b0;
            end
         end
         ST_SRCH_SETTLE: begin
            pend_nxt = pend_eff;
            if (!mpeg_busy) begin
               next_state = pend_eff ? ST_PLAY : ST_PAUSE;
               pend_nxt   = 1'b0;
            end
         end
         default: next_state = ST_STOP;
      endcase
   end

   always_comb begin
      wr_go  = 1'b0;
      wr_dta = 32'h0;
      if (next_state != state) begin
         case (next_state)
            ST_PLAY:       begin wr_go = 1'b1; wr_dta = 32'h1; end
            ST_PAUSE:      begin wr_go = 1'b1; wr_dta = 32'h0; end
            ST_SRCH_FLUSH: begin wr_go = 1'b1; wr_dta = 32'h2; end
            default:       begin wr_go = 1'b0; wr_dta = 32'h0; end
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state            <= ST_STOP;
         pending_play     <= 1'b0;
         v_sync_q         <= 1'b0;
         tmr              <= '0;
         frame_search_req <= 1'b0;
         frame_search     <= '0;
         reg_addr         <= '0;
         reg_wr_en        <= 1'b0;
         reg_dta_in       <= '0;
         is_playing       <= 1'b0;
         is_paused        <= 1'b0;
         is_searching     <= 1'b0;
         cur_frame        <= '0;
         search_err       <= 1'b0;
      end else begin
         state        <= next_state;
         pending_play <= pend_nxt;
         v_sync_q     <= v_sync;
         is_playing   <= (next_state == ST_PLAY);
         is_paused    <= (next_state == ST_PAUSE);
         is_searching <= (next_state == ST_SRCH_FLUSH) || (next_state == ST_SRCH_WAIT) ||
                         (next_state == ST_SRCH_SETTLE);
         search_err   <= srch_tmo;
         reg_wr_en    <= wr_go;
         if (wr_go) begin
            reg_addr   <= REG_CTRL_ADDR;
            reg_dta_in <= wr_dta;
         end
         // timer is a down-counter; expiry is the cycle it sits at zero in WAIT
         if (state == ST_SRCH_FLUSH)                 tmr <= TMR_LOAD;
         else if (state == ST_SRCH_WAIT && tmr != '0) tmr <= tmr - 1'b1;
         if (srch_start) begin
            frame_search     <= clamp_frame;
            frame_search_req <= 1'b1;
         end
         if (srch_done || srch_tmo) frame_search_req <= 1'b0;
         if (srch_done)      cur_frame <= frame_search;
         else if (inc_frame) cur_frame <= cur_frame + 1'b1;
      end
   end

endmodule

// File: tb/tb_ldp_transport_ctrl.sv
// Directed bench for ldp_transport_ctrl: play, search success/clamp/timeout, request priority,
// end-of-disc pause and reset during search.
module tb_ldp_transport_ctrl;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        play_req = 1'b0, pause_req = 1'b0, search_req = 1'b0;
   logic [31:0] search_frame_in = '0;
   logic        search_ack = 1'b0, mpeg_busy = 1'b0, v_sync = 1'b0;
   logic        frame_search_req, reg_wr_en;
   logic [31:0] frame_search, reg_dta_in, cur_frame;
   logic [4:0]  reg_addr;
   logic        is_playing, is_paused, is_searching, search_err;

   int n_cmp = 0;
   int n_bad = 0;

   ldp_transport_ctrl #(
      .FRAME_W(32), .MAX_FRAME(54000), .TIMEOUT_CYC(100), .REG_CTRL_ADDR(5'd0)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .play_req(play_req), .pause_req(pause_req),
      .search_req(search_req), .search_frame_in(search_frame_in), .search_ack(search_ack),
      .mpeg_busy(mpeg_busy), .v_sync(v_sync), .frame_search_req(frame_search_req),
      .frame_search(frame_search), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
      .reg_dta_in(reg_dta_in), .is_playing(is_playing), .is_paused(is_paused),
      .is_searching(is_searching), .cur_frame(cur_frame), .search_err(search_err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic pulse_play();   play_req = 1'b1;   cyc(); play_req = 1'b0;   endtask
   task automatic pulse_pause();  pause_req = 1'b1;  cyc(); pause_req = 1'b0;  endtask
   task automatic pulse_ack();    search_ack = 1'b1; cyc(); search_ack = 1'b0; endtask
   task automatic pulse_search(input logic [31:0] f);
      search_frame_in = f; search_req = 1'b1; cyc(); search_req = 1'b0;
   endtask
   task automatic vsync();
      v_sync = 1'b1; cyc(); cyc(); v_sync = 1'b0; cyc(); cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: reset, play, vsync counting
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      chk("rst_playing", 32'(is_playing), 0);
      chk("rst_paused", 32'(is_paused), 0);
      chk("rst_searching", 32'(is_searching), 0);
      chk("rst_wr_en", 32'(reg_wr_en), 0);
      chk("rst_fsr", 32'(frame_search_req), 0);
      chk("rst_cur_frame", cur_frame, 0);
      pulse_play();
      chk("t1_playing", 32'(is_playing), 1);
      chk("t1_wr_en", 32'(reg_wr_en), 1);
      chk("t1_addr", 32'(reg_addr), 0);
      chk("t1_data", reg_dta_in, 1);
      cyc();
      chk("t1_wr_once", 32'(reg_wr_en), 0);
      chk("t1_data_hold", reg_dta_in, 1);
      pulse_play();
      chk("t1_replay_nowr", 32'(reg_wr_en), 0);
      repeat (3) vsync();
      chk("t1_frames", cur_frame, 3);

      // 2: search 1000, ack after 20 cycles, no play pending
      pulse_search(32'd1000);
      chk("t2_searching", 32'(is_searching), 1);
      chk("t2_playing", 32'(is_playing), 0);
      chk("t2_wr_en", 32'(reg_wr_en), 1);
      chk("t2_data", reg_dta_in, 2);
      chk("t2_fsr", 32'(frame_search_req), 1);
      chk("t2_fs", frame_search, 1000);
      repeat (19) cyc();
      chk("t2_wait_fsr", 32'(frame_search_req), 1);
      chk("t2_wait_frame", cur_frame, 3);
      pulse_ack();
      chk("t2_ack_fsr", 32'(frame_search_req), 0);
      chk("t2_ack_frame", cur_frame, 1000);
      cyc();
      chk("t2_paused", 32'(is_paused), 1);
      chk("t2_pause_wr", 32'(reg_wr_en), 1);
      chk("t2_pause_data", reg_dta_in, 0);

      // 3: clamped target, play during wait, decoder busy at settle
      pulse_search(32'd60000);
      chk("t3_fs_clamp", frame_search, 54000);
      cyc();
      pulse_play();
      mpeg_busy = 1'b1;
      repeat (4) cyc();
      pulse_ack();
      chk("t3_frame", cur_frame, 54000);
      repeat (3) cyc();
      chk("t3_settle_busy", 32'(is_searching), 1);
      mpeg_busy = 1'b0;
      cyc();
      chk("t3_playing", 32'(is_playing), 1);
      chk("t3_play_wr", 32'(reg_wr_en), 1);
      chk("t3_play_data", reg_dta_in, 1);

      // 4: timeout with no ack
      pulse_search(32'd500);
      repeat (100) cyc();
      chk("t4_err_early", 32'(search_err), 0);
      chk("t4_still_fsr", 32'(frame_search_req), 1);
      cyc();
      chk("t4_err", 32'(search_err), 1);
      chk("t4_paused", 32'(is_paused), 1);
      chk("t4_fsr_drop", 32'(frame_search_req), 0);
      chk("t4_frame_kept", cur_frame, 54000);
      chk("t4_data", reg_dta_in, 0);
      cyc();
      chk("t4_err_pulse", 32'(search_err), 0);

      // 5: request priority from STOP
      rst = 1'b1; cyc(); rst = 1'b0;
      search_frame_in = 32'd77;
      play_req = 1'b1; pause_req = 1'b1; search_req = 1'b1;
      cyc();
      play_req = 1'b0; pause_req = 1'b0; search_req = 1'b0;
      chk("t5_searching", 32'(is_searching), 1);
      chk("t5_fs", frame_search, 77);
      cyc();
      pulse_ack();
      cyc();
      chk("t5_paused_no_pend", 32'(is_paused), 1);
      rst = 1'b1; cyc(); rst = 1'b0;
      pulse_pause();
      chk("t5_stop_pause", 32'(is_paused), 0);
      chk("t5_stop_nowr", 32'(reg_wr_en), 0);
      play_req = 1'b1; pause_req = 1'b1;
      cyc();
      play_req = 1'b0; pause_req = 1'b0;
      chk("t5_pause_beats_play", 32'(is_playing), 0);

      // 6: end of disc, then reset mid-search
      pulse_search(32'd53999);
      cyc();
      pulse_ack();
      cyc();
      pulse_play();
      chk("t6_playing", 32'(is_playing), 1);
      vsync();
      chk("t6_last_frame", cur_frame, 54000);
      chk("t6_still_play", 32'(is_playing), 1);
      vsync();
      chk("t6_no_wrap", cur_frame, 54000);
      chk("t6_paused", 32'(is_paused), 1);
      chk("t6_pause_data", reg_dta_in, 0);
      pulse_search(32'd10);
      cyc();
      chk("t6_fsr_up", 32'(frame_search_req), 1);
      rst = 1'b1;
      cyc();
      chk("t6_rst_fsr", 32'(frame_search_req), 0);
      chk("t6_rst_search", 32'(is_searching), 0);
      chk("t6_rst_frame", cur_frame, 0);
      rst = 1'b0;
      cyc();
      chk("t6_rst_nowr", 32'(reg_wr_en), 0);
      chk("t6_rst_stop", 32'({is_playing, is_paused, is_searching}), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
